// File: rtl/fetch_pc.sv
// Program counter and fetch sequencing for the 9-bit core. It drives the ROM address
// and handles start/restart, halt, stall, branches and a saturating run-cycle counter.
module fetch_pc #(
    parameter int IW = 10,
    parameter int OW = 6,
    parameter int CW = 16
) (
    input  logic          Clk,
    input  logic          Reset,
    input  logic          Start,
    input  logic [IW-1:0] StartAddr,
    input  logic          Halt,
    input  logic          Stall,
    input  logic          BranchAbs,
    input  logic          BranchRel,
    input  logic          Taken,
    input  logic [IW-1:0] Target,
    input  logic [OW-1:0] Offset,
    output logic [IW-1:0] InstAddress,
    output logic          Running,
    output logic          Done,
    output logic [CW-1:0] CycleCount
);

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_RUN  = 2'd1;
    localparam logic [1:0] ST_DONE = 2'd2;

    logic [1:0]    state;
    logic [IW-1:0] pc_q;
    logic [IW-1:0] pc_nxt;
    logic [IW-1:0] off_ext;
    logic [CW-1:0] cnt_q;
    logic [CW-1:0] cnt_inc;

    assign off_ext = {{(IW-OW){Offset[OW-1]}}, Offset};
    assign cnt_inc = (cnt_q == {CW{1'b1}}) ? cnt_q : cnt_q + {{(CW-1){1'b0}}, 1'b1};

    // Absolute branch wins over relative when both flags are set.
    always_comb begin
        pc_nxt = pc_q + {{(IW-1){1'b0}}, 1'b1};
        if (BranchAbs && Taken)
            pc_nxt = Target;
        else if (BranchRel && Taken)
            pc_nxt = pc_q + off_ext;
    end

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            state <= ST_IDLE;
            pc_q  <= '0;
            cnt_q <= '0;
        end else begin
            case (state)
                ST_IDLE, ST_DONE: begin
                    if (Start) begin
                        state <= ST_RUN;
                        pc_q  <= StartAddr;
                        cnt_q <= '0;
                    end
                end
                ST_RUN: begin
                    if (Start) begin
                        pc_q  <= StartAddr;
                        cnt_q <= '0;
                    end else begin
                        // Halt and stall edges still count as executed cycles.
                        cnt_q <= cnt_inc;
                        if (Halt)
                            state <= ST_DONE;
                        else if (!Stall)
                            pc_q <= pc_nxt;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    assign InstAddress = pc_q;
    assign Running     = (state == ST_RUN);
    assign Done        = (state == ST_DONE);
    assign CycleCount  = cnt_q;

endmodule

// File: tb/tb_fetch_pc.sv
// Directed bench for fetch_pc: a behavioural reference checked every cycle, plus
// hand-computed expectations at the interesting points.
module tb_fetch_pc;

    logic        Clk = 1'b0;
    logic        Reset = 1'b1;
    logic        Start = 1'b0;
    logic [9:0]  StartAddr = '0;
    logic        Halt = 1'b0, Stall = 1'b0, BranchAbs = 1'b0, BranchRel = 1'b0, Taken = 1'b0;
    logic [9:0]  Target = '0;
    logic [5:0]  Offset = '0;
    logic [9:0]  InstAddress;
    logic        Running, Done;
    logic [15:0] CycleCount;

    logic        start4 = 1'b0;
    logic [9:0]  zaddr = '0;
    logic        zbit = 1'b0;
    logic [5:0]  zoff = '0;
    logic [9:0]  ia4;
    logic        run4, done4;
    logic [3:0]  cnt4;

    int tests = 0;
    int fails = 0;

    fetch_pc dut (
        .Clk(Clk), .Reset(Reset), .Start(Start), .StartAddr(StartAddr),
        .Halt(Halt), .Stall(Stall), .BranchAbs(BranchAbs), .BranchRel(BranchRel),
        .Taken(Taken), .Target(Target), .Offset(Offset),
        .InstAddress(InstAddress), .Running(Running), .Done(Done), .CycleCount(CycleCount)
    );

    fetch_pc #(.IW(10), .OW(6), .CW(4)) dut4 (
        .Clk(Clk), .Reset(Reset), .Start(start4), .StartAddr(zaddr),
        .Halt(zbit), .Stall(zbit), .BranchAbs(zbit), .BranchRel(zbit),
        .Taken(zbit), .Target(zaddr), .Offset(zoff),
        .InstAddress(ia4), .Running(run4), .Done(done4), .CycleCount(cnt4)
    );

    always #5 Clk = ~Clk;

    task automatic check(input string name, input int act, input int exp);
        tests++;
        if (act != exp) begin
            fails++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: plain integer arithmetic over the behavioural rules.
    int m_pc = 0, m_cnt = 0;
    bit m_run = 0, m_done = 0;

    always @(posedge Clk or posedge Reset) begin
        int off;
        if (Reset) begin
            m_pc = 0; m_cnt = 0; m_run = 0; m_done = 0;
        end else if (!m_run) begin
            if (Start) begin
                m_run = 1; m_done = 0; m_pc = int'(StartAddr); m_cnt = 0;
            end
        end else if (Start) begin
            m_pc = int'(StartAddr); m_cnt = 0;
        end else begin
            m_cnt = (m_cnt + 1 > 65535) ? 65535 : m_cnt + 1;
            off = (int'(Offset) >= 32) ? int'(Offset) - 64 : int'(Offset);
            if (Halt) begin
                m_run = 0; m_done = 1;
            end else if (Stall) begin
                m_pc = m_pc;
            end else if (BranchAbs && Taken) begin
                m_pc = int'(Target);
            end else if (BranchRel && Taken) begin
                m_pc = ((m_pc + off) % 1024 + 1024) % 1024;
            end else begin
                m_pc = (m_pc + 1) % 1024;
            end
        end
    end

    always @(negedge Clk) begin
        check("model_addr", int'(InstAddress), m_pc);
        check("model_running", int'(Running), int'(m_run));
        check("model_done", int'(Done), int'(m_done));
        check("model_count", int'(CycleCount), m_cnt);
    end

    task automatic edge_wait();
        @(negedge Clk);
        #1;
    endtask

    task automatic go(input logic [9:0] addr);
        StartAddr = addr;
        Start = 1'b1;
        edge_wait();
        Start = 1'b0;
    endtask

    task automatic clr_ctrl();
        Halt = 0; Stall = 0; BranchAbs = 0; BranchRel = 0; Taken = 0;
        Target = '0; Offset = '0;
    endtask

    initial begin
        edge_wait();
        edge_wait();
        check("rst_addr", int'(InstAddress), 0);
        check("rst_running", int'(Running), 0);
        check("rst_done", int'(Done), 0);
        check("rst_count", int'(CycleCount), 0);
        Reset = 1'b0;
        Halt = 1'b1; BranchAbs = 1'b1; Taken = 1'b1; Target = 10'd77;
        edge_wait();
        check("idle_ignores_ctrl", int'(InstAddress), 0);
        check("idle_running", int'(Running), 0);
        clr_ctrl();

        // 1: sequential from 0
        go(10'd0);
        check("t1_a0", int'(InstAddress), 0);
        check("t1_running", int'(Running), 1);
        for (int i = 1; i <= 3; i++) begin
            edge_wait();
            check("t1_seq", int'(InstAddress), i);
        end

        // 2: wrap at top of address space
        go(10'd1022);
        check("t2_a", int'(InstAddress), 1022); check("t2_c", int'(CycleCount), 0);
        edge_wait();
        check("t2_a", int'(InstAddress), 1023); check("t2_c", int'(CycleCount), 1);
        edge_wait();
        check("t2_a", int'(InstAddress), 0);    check("t2_c", int'(CycleCount), 2);
        edge_wait();
        check("t2_a", int'(InstAddress), 1);    check("t2_c", int'(CycleCount), 3);

        // 3: relative branches
        go(10'd10);
        BranchRel = 1; Taken = 1; Offset = 6'b111101;
        edge_wait();
        check("t3_rel_neg", int'(InstAddress), 7);
        clr_ctrl();
        go(10'd1020);
        BranchRel = 1; Taken = 1; Offset = 6'd31;
        edge_wait();
        check("t3_rel_wrap", int'(InstAddress), 27);
        clr_ctrl();
        go(10'd10);
        BranchRel = 1; Taken = 0; Offset = 6'd20;
        edge_wait();
        check("t3_not_taken", int'(InstAddress), 11);
        clr_ctrl();
        go(10'd10);
        Taken = 1; Target = 10'd500;
        edge_wait();
        check("t3_taken_noflag", int'(InstAddress), 11);
        clr_ctrl();

        // 4: absolute beats relative; stall beats both
        go(10'd40);
        BranchAbs = 1; BranchRel = 1; Taken = 1; Target = 10'd100; Offset = 6'd5;
        edge_wait();
        check("t4_abs_wins", int'(InstAddress), 100);
        go(10'd40);
        Stall = 1;
        edge_wait();
        check("t4_stall", int'(InstAddress), 40);
        check("t4_stall_cnt", int'(CycleCount), 1);
        clr_ctrl();

        // 5: halt then restart from DONE
        go(10'd0);
        repeat (5) edge_wait();
        check("t5_pre_halt", int'(InstAddress), 5);
        Halt = 1;
        edge_wait();
        check("t5_done", int'(Done), 1);
        check("t5_running", int'(Running), 0);
        check("t5_addr", int'(InstAddress), 5);
        check("t5_cnt", int'(CycleCount), 6);
        Stall = 1; BranchAbs = 1; Taken = 1; Target = 10'd9;
        repeat (2) edge_wait();
        check("t5_frozen_addr", int'(InstAddress), 5);
        check("t5_frozen_cnt", int'(CycleCount), 6);
        check("t5_frozen_done", int'(Done), 1);
        clr_ctrl();
        go(10'd200);
        check("t5_restart_done", int'(Done), 0);
        check("t5_restart_run", int'(Running), 1);
        check("t5_restart_addr", int'(InstAddress), 200);
        check("t5_restart_cnt", int'(CycleCount), 0);

        // 6: async reset between edges, then counter saturation at CW=4
        go(10'd298);
        repeat (2) edge_wait();
        check("t6_pre_rst", int'(InstAddress), 300);
        #1 Reset = 1'b1;
        #1;
        check("t6_rst_addr", int'(InstAddress), 0);
        check("t6_rst_running", int'(Running), 0);
        check("t6_rst_cnt", int'(CycleCount), 0);
        Reset = 1'b0;
        edge_wait();
        check("t6_idle_after", int'(InstAddress), 0);
        go(10'd5);
        check("t6_start_after", int'(InstAddress), 5);
        check("t6_start_running", int'(Running), 1);

        start4 = 1'b1;
        edge_wait();
        start4 = 1'b0;
        check("t6_cw4_start", int'(cnt4), 0);
        repeat (14) edge_wait();
        check("t6_cw4_14", int'(cnt4), 14);
        repeat (6) edge_wait();
        check("t6_cw4_sat", int'(cnt4), 15);
        check("t6_cw4_run", int'(run4), 1);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
